// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side bus bundle for icache_direct.
//   if_en / if_pc      : fetch request valid and 4-byte aligned address
//   if_done / if_inst  : one-cycle response pulse and instruction word
//   mem_en / mem_pc    : line-fill request and line-aligned fill address
//   mem_done / mem_data: one-cycle fill pulse and packed line (byte 0 at [7:0])
// The cache connects through the slave modport; fetch unit and memory
// controller (or a testbench standing in for both) use the master modport.
interface icache_direct_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BLK_BYTES = 16
);
    logic                   if_en;
    logic [ADDR_W-1:0]      if_pc;
    logic                   if_done;
    logic [31:0]            if_inst;
    logic                   mem_en;
    logic [ADDR_W-1:0]      mem_pc;
    logic                   mem_done;
    logic [8*BLK_BYTES-1:0] mem_data;

    modport slave (
        input  if_en, if_pc, mem_done, mem_data,
        output if_done, if_inst, mem_en, mem_pc
    );

    modport master (
        output if_en, if_pc, mem_done, mem_data,
        input  if_done, if_inst, mem_en, mem_pc
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache.
// Hits answer one cycle after the request; misses fetch a whole line from the
// memory controller, install it, then answer from the freshly filled line.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   rdy      : global ready; when low every register holds
//   rollback : pipeline flush; cancels the response of an outstanding fetch
//   bus      : icache_direct_if.slave carrying fetch and fill handshakes
module icache_direct #(
    parameter int unsigned BLK_BYTES = 16,
    parameter int unsigned NUM_BLK   = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           rollback,
    icache_direct_if.slave bus
);
    localparam int unsigned OFF    = $clog2(BLK_BYTES);
    localparam int unsigned IDX    = $clog2(NUM_BLK);
    localparam int unsigned TAG    = ADDR_W - OFF - IDX;
    localparam int unsigned LINE_W = 8 * BLK_BYTES;

    typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                drop_q, drop_d;
    logic                if_done_q, if_done_d;
    logic [31:0]         if_inst_q, if_inst_d;
    logic                mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]   mem_pc_q, mem_pc_d;
    logic [NUM_BLK-1:0]  valid_q;

    logic [LINE_W-1:0]   data_q [NUM_BLK];
    logic [TAG-1:0]      tag_q  [NUM_BLK];

    logic [IDX-1:0]      req_idx;
    logic [TAG-1:0]      req_tag;
    logic [IDX-1:0]      miss_idx;
    logic [TAG-1:0]      miss_tag;
    logic                hit;
    logic                accept;
    logic                fill_we;

    // Select the 32-bit word addressed by a byte offset; the two low offset
    // bits are masked so the result is always word aligned.
    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0] line,
                                              input logic [OFF-1:0]    off);
        logic [OFF+2:0] base;
        base = {off & ~OFF'(3), 3'b000};
        return line[base +: 32];
    endfunction

    assign req_idx  = bus.if_pc[OFF+IDX-1:OFF];
    assign req_tag  = bus.if_pc[ADDR_W-1:OFF+IDX];
    assign miss_idx = pc_q[OFF+IDX-1:OFF];
    assign miss_tag = pc_q[ADDR_W-1:OFF+IDX];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // A request is refused while a response pulse is on the bus so that
    // if_done can never be high on two consecutive cycles.
    assign accept   = bus.if_en && !rollback && !if_done_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept && !hit) state_d = StMiss;
            StMiss: if (bus.mem_done)   state_d = StResp;
            StResp:                     state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        pc_d      = pc_q;
        drop_d    = drop_q;
        if_done_d = 1'b0;
        if_inst_d = if_inst_q;
        mem_en_d  = mem_en_q;
        mem_pc_d  = mem_pc_q;
        fill_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hit) begin
                        if_done_d = 1'b1;
                        if_inst_d = pick_word(data_q[req_idx], bus.if_pc[OFF-1:0]);
                    end else begin
                        pc_d     = bus.if_pc;
                        mem_en_d = 1'b1;
                        mem_pc_d = {bus.if_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                    end
                end
            end
            StMiss: begin
                // The controller cannot abort a fill, so a rollback only
                // suppresses the eventual response.
                drop_d = drop_q | rollback;
                if (bus.mem_done) begin
                    fill_we  = 1'b1;
                    mem_en_d = 1'b0;
                end
            end
            StResp: begin
                if (!drop_q) begin
                    if_done_d = 1'b1;
                    if_inst_d = pick_word(data_q[miss_idx], pc_q[OFF-1:0]);
                end
                drop_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            drop_q    <= 1'b0;
            if_done_q <= 1'b0;
            if_inst_q <= '0;
            mem_en_q  <= 1'b0;
            mem_pc_q  <= '0;
            valid_q   <= '0;
        end else if (rdy) begin
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            if_done_q <= if_done_d;
            if_inst_q <= if_inst_d;
            mem_en_q  <= mem_en_d;
            mem_pc_q  <= mem_pc_d;
            if (fill_we) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Line and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            data_q[miss_idx] <= bus.mem_data;
            tag_q[miss_idx]  <= miss_tag;
        end
    end

    assign bus.if_done = if_done_q;
    assign bus.if_inst = if_inst_q;
    assign bus.mem_en  = mem_en_q;
    assign bus.mem_pc  = mem_pc_q;
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios followed by
// randomized fetches, scored against a line-level model of cache residency
// over a synthetic instruction memory.
module tb_icache_direct;
    localparam int unsigned BLK_BYTES = 16;
    localparam int unsigned NUM_BLK   = 16;
    localparam int unsigned ADDR_W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rollback = 1'b0;

    int checks = 0;
    int errors = 0;

    bit          m_valid [NUM_BLK];
    int unsigned m_tag   [NUM_BLK];

    icache_direct_if #(.ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES)) bus ();

    icache_direct #(
        .BLK_BYTES(BLK_BYTES),
        .NUM_BLK  (NUM_BLK),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .rollback(rollback),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'h0050_0093;
        if (a == 32'h0000_100C) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [8*BLK_BYTES-1:0] mem_line(input logic [31:0] base);
        logic [8*BLK_BYTES-1:0] line;
        for (int w = 0; w < BLK_BYTES / 4; w++) begin
            line[w*32 +: 32] = mem_word(base + 32'(w * 4));
        end
        return line;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / BLK_BYTES) % NUM_BLK;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (BLK_BYTES * NUM_BLK);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    // One complete fetch. rb_at selects the miss-wait cycle carrying a
    // rollback pulse (== delay: the mem_done cycle; -1: none).
    task automatic fetch(input logic [31:0] pc, input int rb_at, input bit stall,
                         input int delay);
        bit          exp_hit;
        bit          dropped;
        logic [31:0] base;
        exp_hit = model_hit(pc);
        dropped = 1'b0;
        base    = pc & ~32'(BLK_BYTES - 1);
        bus.if_en = 1'b1;
        bus.if_pc = pc;
        step();
        bus.if_en = 1'b0;
        bus.if_pc = $urandom & ~32'h3;
        if (exp_hit) begin
            check("hit_done", bus.if_done, 1);
            check("hit_inst", bus.if_inst, mem_word(pc));
            check("hit_memen", bus.mem_en, 0);
            step();
            check("hit_pulse", bus.if_done, 0);
            return;
        end
        check("miss_memen", bus.mem_en, 1);
        check("miss_pc", bus.mem_pc, base);
        check("miss_nodone", bus.if_done, 0);
        for (int i = 0; i < delay; i++) begin
            if (i == rb_at) begin
                rollback = 1'b1;
                dropped  = 1'b1;
            end
            step();
            rollback = 1'b0;
            check("wait_memen", bus.mem_en, 1);
            check("wait_pc", bus.mem_pc, base);
            check("wait_nodone", bus.if_done, 0);
        end
        bus.mem_done = 1'b1;
        bus.mem_data = mem_line(base);
        if (stall) begin
            rdy = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                check("stall_memen", bus.mem_en, 1);
                check("stall_nodone", bus.if_done, 0);
            end
            rdy = 1'b1;
        end
        if (rb_at == delay) begin
            rollback = 1'b1;
            dropped  = 1'b1;
        end
        step();
        rollback     = 1'b0;
        bus.mem_done = 1'b0;
        bus.mem_data = {4{$urandom}};
        check("fill_memen", bus.mem_en, 0);
        check("fill_nodone", bus.if_done, 0);
        m_valid[idx_of(pc)] = 1'b1;
        m_tag[idx_of(pc)]   = tag_of(pc);
        step();
        check("resp_done", bus.if_done, !dropped);
        if (!dropped) check("resp_inst", bus.if_inst, mem_word(pc));
        step();
        check("resp_pulse", bus.if_done, 0);
    endtask

    initial begin
        logic [31:0] pc;
        int          delay;
        int          rb_at;
        bus.if_en    = 1'b0;
        bus.if_pc    = '0;
        bus.mem_done = 1'b0;
        bus.mem_data = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end
        step();
        step();
        check("rst_done", bus.if_done, 0);
        check("rst_inst", bus.if_inst, 0);
        check("rst_memen", bus.mem_en, 0);
        check("rst_mempc", bus.mem_pc, 0);
        rst = 1'b0;
        step();

        // Cold miss then hit in the same line.
        fetch(32'h0000_1004, -1, 1'b0, 2);
        fetch(32'h0000_100C, -1, 1'b0, 0);

        // if_en held across a hit: the pulse is followed by a fresh lookup.
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_1008;
        step();
        check("hold_done1", bus.if_done, 1);
        check("hold_inst1", bus.if_inst, mem_word(32'h0000_1008));
        step();
        check("hold_gap", bus.if_done, 0);
        step();
        check("hold_done2", bus.if_done, 1);
        bus.if_en = 1'b0;
        step();
        check("hold_end", bus.if_done, 0);

        // Index aliasing evicts and re-misses.
        fetch(32'h0000_1100, -1, 1'b0, 1);
        fetch(32'h0000_1000, -1, 1'b0, 1);

        // Rollback during miss, then the same pc hits.
        fetch(32'h0000_2040, 1, 1'b0, 3);
        fetch(32'h0000_2040, -1, 1'b0, 0);

        // rdy stall while mem_done is presented.
        fetch(32'h0000_3084, -1, 1'b1, 1);

        // Hit pulse held while rdy is low.
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_3088;
        step();
        bus.if_en = 1'b0;
        rdy = 1'b0;
        check("rdy_pulse0", bus.if_done, 1);
        step();
        check("rdy_pulse1", bus.if_done, 1);
        check("rdy_inst", bus.if_inst, mem_word(32'h0000_3088));
        rdy = 1'b1;
        step();
        check("rdy_pulse_end", bus.if_done, 0);

        // Asynchronous reset in the middle of a miss.
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_4000;
        step();
        bus.if_en = 1'b0;
        check("arst_pre_memen", bus.mem_en, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_memen", bus.mem_en, 0);
        check("arst_mempc", bus.mem_pc, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < NUM_BLK; i++) m_valid[i] = 1'b0;
        step();
        bus.mem_done = 1'b1;
        bus.mem_data = mem_line(32'h0000_4000);
        step();
        bus.mem_done = 1'b0;
        check("stray_memen", bus.mem_en, 0);
        check("stray_done", bus.if_done, 0);
        fetch(32'h0000_100C, -1, 1'b0, 1);

        // Rollback wins over a simultaneous request.
        bus.if_en = 1'b1;
        bus.if_pc = 32'h0000_100C;
        rollback  = 1'b1;
        step();
        bus.if_en = 1'b0;
        rollback  = 1'b0;
        check("rbwin_done", bus.if_done, 0);
        check("rbwin_memen", bus.mem_en, 0);
        step();

        // Randomized traffic over 4 tags x 16 indices.
        for (int n = 0; n < 250; n++) begin
            pc = 32'h0000_1000 | (32'($urandom_range(0, 3)) << 8)
               | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
            delay = int'($urandom_range(0, 4));
            rb_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, delay)) : -1;
            if ($urandom_range(0, 9) == 0) begin
                bus.if_en = 1'b1;
                bus.if_pc = pc;
                rollback  = 1'b1;
                step();
                bus.if_en = 1'b0;
                rollback  = 1'b0;
                check("rnd_rbwin_done", bus.if_done, 0);
                check("rnd_rbwin_memen", bus.mem_en, 0);
            end else begin
                fetch(pc, rb_at, $urandom_range(0, 5) == 0, delay);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetch unit and the memory controller's ifetch port.
- Serves 32-bit instruction reads by PC.
- On a miss, requests one whole line through mem_en/mem_pc and accepts the packed line on mem_done, byte 0 at bits [7:0].
- Survives pipeline rollback without corrupting the tag array.

Parameters:
BLK_BYTES, 16, line size in bytes (power of 2, ≥4); equals the memory controller's ifetch block size.
NUM_BLK, 16, number of lines (power of 2).
ADDR_W, 32, PC/address width.
- Derived: OFF = log2(BLK_BYTES); IDX = log2(NUM_BLK); TAG = ADDR_W-OFF-IDX.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset, asynchronous, active-high; clears all state immediately.
rdy  in  1  global ready; when low, all state and outputs hold.
rollback  in  1  pipeline flush; drops the pending fetch response.
if_en  in  1  fetch request valid.
if_pc  in  ADDR_W  fetch address; 4-byte aligned.
if_done  out  1  one-cycle pulse: if_inst is valid.
if_inst  out  32  instruction word.
mem_en  out  1  line-fill request to the memory controller.
mem_pc  out  ADDR_W  line-aligned fill address (low OFF bits zero).
mem_done  in  1  one-cycle pulse: mem_data is valid.
mem_data  in  8*BLK_BYTES  filled line.

Behaviour:
- Reset values: if_done=0, if_inst=0, mem_en=0, mem_pc=0, all valid bits=0, state=IDLE. Data/tag arrays need no reset.
- Address split: offset = pc[OFF-1:0]; word = pc[OFF-1:2]; index = pc[OFF+IDX-1:OFF]; tag = pc[ADDR_W-1:OFF+IDX].
- rdy=0: no register changes, including if_done. Any pulse in flight is held until rdy returns.
- States: IDLE, MISS, RESP.
- IDLE, if_done default 0:
  - if_en=1, rollback=0, hit (valid[index] and tag match): next edge if_done=1, if_inst=line word. Hit latency is 1 cycle.
  - if_en=1, rollback=0, miss: latch pc; mem_pc={pc[ADDR_W-1:OFF], OFF'b0}; mem_en=1; go to MISS.
  - rollback=1 in IDLE: ignore if_en.
- MISS:
  - mem_en stays high and mem_pc stays stable until mem_done is seen.
  - On mem_done: write the line into data[index]; tag[index]=latched tag; valid[index]=1; mem_en=0 on the same edge; go to RESP.
  - A rollback seen in MISS at any time, including the mem_done cycle, sets a sticky drop flag. The memory controller cannot abort an ifetch, so the fill still completes and is still written.
- RESP (one cycle):
  - If the drop flag is clear: if_done=1, if_inst=word of the filled line.
  - If set: no if_done, clear the flag.
  - Return to IDLE in both cases. A new request is accepted at the earliest on the cycle after RESP.
- if_done is never high for two consecutive cycles. A requester holding if_en high after if_done gets a fresh lookup.
- if_pc changing while in MISS/RESP is ignored; the latched pc is used.
- Simultaneous if_en and rollback in IDLE: rollback wins, no request.
- rst mid-MISS: all valid bits clear and mem_en drops asynchronously. A later stray mem_done in IDLE is ignored.
- mem_done while not in MISS: ignored.
- Index aliasing: a fill overwrites the resident line unconditionally.

Test Plan:
- Cold miss: after reset, if_en=1, if_pc=0x0000_1004 → next edge mem_en=1, mem_pc=0x0000_1000. Drive mem_done with mem_data word1=0x00500093 → one cycle later if_done=1, if_inst=0x00500093; mem_en=0.
- Hit: next request if_pc=0x0000_100C (same line, word3=0x00A00113) → if_done on the following edge with if_inst=0x00A00113, mem_en stays 0.
- Alias eviction (NUM_BLK=16, BLK_BYTES=16): fetch 0x0000_1000, then 0x0000_1100 (same index 0, different tag) → miss with mem_pc=0x0000_1100. A re-fetch of 0x0000_1000 misses again.
- Rollback during miss: pulse rollback 2 cycles after mem_en rises → mem_en held until mem_done, no if_done ever. A subsequent fetch of the same pc hits in 1 cycle.
- rdy stall: drop rdy for 3 cycles on the cycle mem_done would be consumed, holding mem_done → on rdy=1 the line is written once and if_done pulses exactly once.
- Async reset mid-MISS: assert rst between edges → mem_en=0 immediately; after release, a fetch of the previously cached pc misses.
